// File: rtl/aes_dec_round_sched.sv
// Round scheduler for the AES decrypt datapath.
// Chains ARK/ISB/IMC children via ap_ctrl_hs and owns the statemt port mux.
module aes_dec_round_sched #(
  parameter int RND_W = 5
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [RND_W-1:0] rounds,
  output logic             err,
  output logic             ark_start,
  input  logic             ark_done,
  output logic [RND_W-1:0] ark_n,
  output logic             isb_start,
  input  logic             isb_done,
  output logic             imc_start,
  input  logic             imc_done,
  output logic [1:0]       statemt_sel
);

  typedef enum logic [7:0] {
    S_IDLE = 8'h01,
    S_ARK0 = 8'h02,
    S_ISB  = 8'h04,
    S_ARK  = 8'h08,
    S_IMC  = 8'h10,
    S_FISB = 8'h20,
    S_FARK = 8'h40,
    S_FIN  = 8'h80
  } state_t;

  state_t           r_state;
  logic [RND_W-1:0] r_rnd;
  logic [RND_W-1:0] r_ark_n;
  logic             r_err;

  logic             w_idle;
  logic             w_fin;
  logic             w_legal;
  logic             w_step;
  logic [RND_W-1:0] w_rnd_dec;

  assign w_idle    = (r_state == S_IDLE);
  assign w_fin     = (r_state == S_FIN);
  assign w_rnd_dec = r_rnd - RND_W'(1);
  assign w_legal   = (rounds == RND_W'(10)) ||
                     (rounds == RND_W'(12)) ||
                     (rounds == RND_W'(14));

  always_comb begin
    ark_start = (r_state == S_ARK0) ||
                (r_state == S_ARK)  ||
                (r_state == S_FARK);
    isb_start = (r_state == S_ISB) ||
                (r_state == S_FISB);
    imc_start = (r_state == S_IMC);
    statemt_sel = 2'd0;
    unique case (1'b1)
      ark_start: statemt_sel = 2'd1;
      isb_start: statemt_sel = 2'd2;
      imc_start: statemt_sel = 2'd3;
      default:   statemt_sel = 2'd0;
    endcase
  end

  // A child's done only counts while we are holding its start
  assign w_step = (ark_start & ark_done) |
                  (isb_start & isb_done) |
                  (imc_start & imc_done);

  assign ap_idle  = w_idle & ~ap_start;
  assign ap_done  = ap_idle | w_fin;
  assign ap_ready = w_fin;
  assign ark_n    = r_ark_n;
  assign err      = r_err;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_rnd   <= '0;
      r_ark_n <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_rnd   <= rounds;
            r_ark_n <= rounds;
            r_err   <= ~w_legal;
            r_state <= w_legal ? S_ARK0 : S_FIN;
          end
        end
        S_ARK0: begin
          if (w_step) begin
            r_rnd   <= w_rnd_dec;
            r_ark_n <= w_rnd_dec;
            r_state <= S_ISB;
          end
        end
        S_ISB: begin
          if (w_step) r_state <= S_ARK;
        end
        S_ARK: begin
          if (w_step) r_state <= S_IMC;
        end
        S_IMC: begin
          if (w_step) begin
            r_rnd   <= w_rnd_dec;
            r_ark_n <= w_rnd_dec;
            r_state <= (r_rnd > RND_W'(1)) ? S_ISB : S_FISB;
          end
        end
        S_FISB: begin
          if (w_step) r_state <= S_FARK;
        end
        S_FARK: begin
          if (w_step) r_state <= S_FIN;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_round_sched.sv
// Bench for aes_dec_round_sched: HLS-style child models plus
// a step-event scoreboard of (statemt_sel, ark_n) per completed step.
module tb_aes_dec_round_sched;

  localparam int RND_W = 5;

  logic             clk = 1'b0;
  logic             ap_rst;
  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_ready;
  logic [RND_W-1:0] rounds;
  logic             err;
  logic             ark_start;
  logic             ark_done;
  logic [RND_W-1:0] ark_n;
  logic             isb_start;
  logic             isb_done;
  logic             imc_start;
  logic             imc_done;
  logic [1:0]       statemt_sel;

  always #5 clk = ~clk;

  aes_dec_round_sched #(.RND_W(RND_W)) dut (
    .ap_clk      (clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .rounds      (rounds),
    .err         (err),
    .ark_start   (ark_start),
    .ark_done    (ark_done),
    .ark_n       (ark_n),
    .isb_start   (isb_start),
    .isb_done    (isb_done),
    .imc_start   (imc_start),
    .imc_done    (imc_done),
    .statemt_sel (statemt_sel)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Child models: done lat cycles after start, optionally done while idle
  int   lat = 3;
  bit   idle_done = 1'b0;
  logic [2:0] st;
  logic busy [3];
  int   cnt [3];

  assign st = {imc_start, isb_start, ark_start};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ap_rst) begin
        busy[i] <= 1'b0;
      end else if (!busy[i]) begin
        if (st[i]) begin
          busy[i] <= 1'b1;
          cnt[i]  <= lat - 1;
        end
      end else if (cnt[i] == 0) begin
        busy[i] <= 1'b0;
      end else begin
        cnt[i] <= cnt[i] - 1;
      end
    end
  end

  always_comb begin
    ark_done = busy[0] ? (cnt[0] == 0) : (idle_done && !st[0]);
    isb_done = busy[1] ? (cnt[1] == 0) : (idle_done && !st[1]);
    imc_done = busy[2] ? (cnt[2] == 0) : (idle_done && !st[2]);
  end

  // Scoreboard of expected step completions
  int q[$];

  function automatic int ev(input int s, input int n);
    return s * 32 + n;
  endfunction

  task automatic push_seq(input int r);
    q.push_back(ev(1, r));
    for (int i = r - 1; i >= 1; i--) begin
      q.push_back(ev(2, i));
      q.push_back(ev(1, i));
      q.push_back(ev(3, i));
    end
    q.push_back(ev(2, 0));
    q.push_back(ev(1, 0));
  endtask

  int         n_st [3] = '{0, 0, 0};
  int         stab = 0;
  int         exp_ev;
  logic [2:0] p_st = 3'b000;
  logic [RND_W-1:0] p_n = '0;

  always @(negedge clk) begin
    p_st <= st;
    p_n  <= ark_n;
    for (int i = 0; i < 3; i++)
      if (st[i] && !p_st[i]) n_st[i] <= n_st[i] + 1;
    if (ark_start && p_st[0] && ark_n != p_n) stab <= stab + 1;
    if ((ark_start && ark_done) ||
        (isb_start && isb_done) ||
        (imc_start && imc_done)) begin
      exp_ev = (q.size() > 0) ? q.pop_front() : -1;
      check("step", int'({statemt_sel, ark_n}), exp_ev);
    end
  end

  task automatic do_run(input int r, input int mid_r, input bit drop);
    bit legal;
    bit seen;
    int k, gaps, a0, i0, m0, s0, exp_k;
    legal = (r == 10 || r == 12 || r == 14);
    if (legal) push_seq(r);
    a0 = n_st[0];
    i0 = n_st[1];
    m0 = n_st[2];
    s0 = stab;
    rounds   = RND_W'(r);
    ap_start = 1'b1;
    gaps = 0;
    seen = 1'b0;
    k    = 0;
    while (k < 3000 && !seen) begin
      #1;
      if (ap_ready) begin
        seen = 1'b1;
      end else begin
        if (st == 3'b000) gaps++;
        if (k == 3) rounds = RND_W'(mid_r);
        k++;
        @(negedge clk);
      end
    end
    exp_k = legal ? 1 + 3 * r * (lat + 1) : 1;
    check("ready_seen", int'(seen), 1);
    check("latency", k, exp_k);
    check("done_w_ready", int'(ap_done), 1);
    check("err", int'(err), int'(!legal));
    check("gaps", gaps, 1);
    check("fin_ark_n", int'(ark_n), legal ? 0 : r);
    check("n_ark", n_st[0] - a0, legal ? r + 1 : 0);
    check("n_isb", n_st[1] - i0, legal ? r : 0);
    check("n_imc", n_st[2] - m0, legal ? r - 1 : 0);
    check("ark_n_stable", stab - s0, 0);
    check("q_left", q.size(), 0);
    if (drop) ap_start = 1'b0;
    @(negedge clk);
    #1;
    check("ready_pulse", int'(ap_ready), 0);
    if (drop) begin
      check("idle", int'(ap_idle), 1);
      check("idle_done", int'(ap_done), 1);
      check("err_sticky", int'(err), int'(!legal));
    end
  endtask

  task automatic reset_mid_run();
    int k;
    lat = 3;
    push_seq(10);
    rounds   = RND_W'(10);
    ap_start = 1'b1;
    k = 0;
    while (k < 2000 && !(imc_start && ark_n == RND_W'(5))) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("imc5_seen", int'(imc_start && ark_n == RND_W'(5)), 1);
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    @(negedge clk);
    #1;
    check("rst_starts", int'(st), 0);
    check("rst_sel", int'(statemt_sel), 0);
    check("rst_idle", int'(ap_idle), 1);
    check("rst_done", int'(ap_done), 1);
    check("rst_ark_n", int'(ark_n), 0);
    check("rst_err", int'(err), 0);
    ap_rst = 1'b0;
    q.delete();
  endtask

  initial begin
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    rounds   = '0;
    repeat (2) @(negedge clk);
    ap_rst = 1'b0;
    #1;
    check("por_idle", int'(ap_idle), 1);
    check("por_done", int'(ap_done), 1);
    check("por_ready", int'(ap_ready), 0);
    check("por_starts", int'(st), 0);
    check("por_sel", int'(statemt_sel), 0);
    check("por_err", int'(err), 0);
    check("por_ark_n", int'(ark_n), 0);
    @(negedge clk);
    #1;

    lat = 3;
    do_run(10, 10, 1'b1);

    lat = 1;
    do_run(14, 14, 1'b1);

    do_run(11, 11, 1'b1);
    do_run(12, 12, 1'b1);

    idle_done = 1'b1;
    lat = 2;
    repeat (4) @(negedge clk);
    #1;
    check("idle_hold", int'(ap_idle), 1);
    do_run(12, 12, 1'b1);
    do_run(10, 10, 1'b1);
    idle_done = 1'b0;

    reset_mid_run();
    @(negedge clk);
    #1;
    lat = 3;
    do_run(10, 10, 1'b1);

    lat = 1;
    do_run(10, 12, 1'b0);
    do_run(12, 12, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
